// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Optional feature macro: MISALIGNED_SPLIT_EN (split misaligned accesses into byte accesses).
package load_store_unit_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned IDX_W  = 2;

    typedef logic [ADDR_W-1:0] word_address;
    typedef logic [DATA_W-1:0] word;
    typedef logic [SIZE_W-1:0] load_type;

    localparam load_type BYTE     = 2'd0;
    localparam load_type HALFWORD = 2'd1;
    localparam load_type WORD     = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ISSUE_B,
        CAPTURE_B,
        RESP
    } lsu_state_t;

    typedef struct packed {
        logic        is_store;
        word_address addr;
        word         wdata;
        load_type    size;
        logic        is_unsigned;
    } lsu_req_t;

    // Only the two low address bits decide alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input load_type lt);
        case (lt)
            HALFWORD: return addr_lo[0];
            WORD:     return |addr_lo;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input load_type lt);
        case (lt)
            BYTE:     return 3'd1;
            HALFWORD: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    // Right-justify store data; unused upper bits are driven to zero.
    function automatic word store_align(input word data, input load_type lt);
        case (lt)
            BYTE:     return {24'h0, data[7:0]};
            HALFWORD: return {16'h0, data[15:0]};
            default:  return data;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// Combinational sign/zero extension of right-justified load data.
module load_extender
    import load_store_unit_pkg::*;
(
    input  word      i_data,
    input  load_type i_size,
    input  logic     i_unsigned,
    output word      o_result_c
);

    always_comb begin
        o_result_c = i_data;
        case (i_size)
            BYTE:     o_result_c = {{24{~i_unsigned & i_data[7]}}, i_data[7:0]};
            HALFWORD: o_result_c = {{16{~i_unsigned & i_data[15]}}, i_data[15:0]};
            default:  o_result_c = i_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator for data_memory: one load/store at a time, big-endian, extended load data.
// Optional feature macro: MISALIGNED_SPLIT_EN (misaligned accesses split into byte accesses instead of faulting).
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_how_much,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t  r_state, w_next_state;
    lsu_req_t    r_req, w_req, w_in_req;
    logic        r_ready, r_resp_valid, r_fault, w_fault_nxt, w_accept;
    logic        r_mem_read, r_mem_write, w_read_nxt, w_write_nxt;
    word_address r_mem_addr, w_addr_nxt;
    word         r_mem_wdata, w_wdata_nxt, w_ext_src, w_ext;
    load_type    r_mem_how_much, w_how_nxt;
`ifdef MISALIGNED_SPLIT_EN
    logic             r_split, w_split_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt, w_last_idx, w_byte_sel;
    word              r_acc, w_acc_nxt;
    logic [7:0]       w_store_byte;
`endif

    assign w_accept = req_valid && r_ready;
    assign w_in_req = '{is_store: req_is_store, addr: req_addr, wdata: req_wdata,
                        size: req_size, is_unsigned: req_unsigned};

    // Next state, request capture and split bookkeeping.
    always_comb begin
        w_next_state = r_state;
        w_req        = r_req;
        w_fault_nxt  = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
        w_split_nxt  = r_split;
        w_idx_nxt    = r_idx;
        w_acc_nxt    = r_acc;
        w_last_idx   = IDX_W'(size_bytes(r_req.size) - 3'd1);
`endif
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_req = w_in_req;
                    if (is_misaligned(req_addr[1:0], req_size)) begin
`ifdef MISALIGNED_SPLIT_EN
                        w_next_state = ISSUE_B;
                        w_split_nxt  = 1'b1;
                        w_idx_nxt    = '0;
                        w_acc_nxt    = '0;
`else
                        w_next_state = RESP;
                        w_fault_nxt  = 1'b1;
`endif
                    end else begin
                        w_next_state = ISSUE;
`ifdef MISALIGNED_SPLIT_EN
                        w_split_nxt  = 1'b0;
`endif
                    end
                end
            end
            ISSUE: w_next_state = RESP;
`ifdef MISALIGNED_SPLIT_EN
            ISSUE_B: w_next_state = CAPTURE_B;
            CAPTURE_B: begin
                w_acc_nxt = {r_acc[23:0], mem_rdata[7:0]};
                if (r_idx == w_last_idx) begin
                    w_next_state = RESP;
                end else begin
                    w_idx_nxt    = r_idx + IDX_W'(1);
                    w_next_state = ISSUE_B;
                end
            end
`endif
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Memory-side outputs for the coming cycle, decoded from next state so they leave a flop.
    always_comb begin
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
        w_addr_nxt  = '0;
        w_wdata_nxt = '0;
        w_how_nxt   = WORD;
`ifdef MISALIGNED_SPLIT_EN
        w_byte_sel   = IDX_W'(size_bytes(w_req.size) - 3'd1) - w_idx_nxt;
        w_store_byte = 8'(w_req.wdata >> {w_byte_sel, 3'b000});
`endif
        case (w_next_state)
            ISSUE: begin
                w_read_nxt  = !w_req.is_store;
                w_write_nxt = w_req.is_store;
                w_addr_nxt  = w_req.addr;
                w_how_nxt   = w_req.size;
                if (w_req.is_store) w_wdata_nxt = store_align(w_req.wdata, w_req.size);
            end
`ifdef MISALIGNED_SPLIT_EN
            ISSUE_B: begin
                w_read_nxt  = !w_req.is_store;
                w_write_nxt = w_req.is_store;
                w_addr_nxt  = w_req.addr + ADDR_W'(w_idx_nxt);
                w_how_nxt   = BYTE;
                if (w_req.is_store) w_wdata_nxt = {24'h0, w_store_byte};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_req          <= '0;
            r_ready        <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_fault        <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_how_much <= WORD;
`ifdef MISALIGNED_SPLIT_EN
            r_split        <= 1'b0;
            r_idx          <= '0;
            r_acc          <= '0;
`endif
        end else begin
            r_state        <= w_next_state;
            r_req          <= w_req;
            r_ready        <= (w_next_state == IDLE);
            r_resp_valid   <= (w_next_state == RESP);
            r_fault        <= w_fault_nxt;
            r_mem_read     <= w_read_nxt;
            r_mem_write    <= w_write_nxt;
            r_mem_addr     <= w_addr_nxt;
            r_mem_wdata    <= w_wdata_nxt;
            r_mem_how_much <= w_how_nxt;
`ifdef MISALIGNED_SPLIT_EN
            r_split        <= w_split_nxt;
            r_idx          <= w_idx_nxt;
            r_acc          <= w_acc_nxt;
`endif
        end
    end

    // Aligned loads take data straight from the memory's output register.
`ifdef MISALIGNED_SPLIT_EN
    assign w_ext_src = r_split ? r_acc : mem_rdata;
`else
    assign w_ext_src = mem_rdata;
`endif

    load_extender u_load_extender (
        .i_data     (w_ext_src),
        .i_size     (r_req.size),
        .i_unsigned (r_req.is_unsigned),
        .o_result_c (w_ext)
    );

    assign req_ready    = r_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_fault   = r_fault;
    assign resp_rdata   = (r_resp_valid && !r_req.is_store && !r_fault) ? w_ext : '0;
    assign mem_read     = r_mem_read;
    assign mem_write    = r_mem_write;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_how_much = r_mem_how_much;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a big-endian data_memory model and a byte-array reference model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_is_store, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_how_much;

    int errors = 0;
    int checks = 0;
    int n_access = 0;
    bit both_seen = 1'b0;
    logic [7:0] ref_mem [256];

    always #5 clock = ~clock;

    load_store_unit dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_how_much(mem_how_much), .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 167) ^ 8'h5A);
    endfunction

    // data_memory stand-in: big-endian, registered read data.
    initial begin : data_memory
        logic [7:0] dmem [256];
        for (int i = 0; i < 256; i++) dmem[i] = init_byte(i);
        mem_rdata = '0;
        forever begin
            @(posedge clock);
            if (mem_write) begin
                case (mem_how_much)
                    BYTE: dmem[mem_addr[7:0]] <= mem_wdata[7:0];
                    HALFWORD: begin
                        dmem[8'(mem_addr)]     <= mem_wdata[15:8];
                        dmem[8'(mem_addr + 1)] <= mem_wdata[7:0];
                    end
                    default: for (int k = 0; k < 4; k++)
                        dmem[8'(mem_addr + 32'(k))] <= mem_wdata[31 - 8*k -: 8];
                endcase
            end
            if (mem_read) begin
                case (mem_how_much)
                    BYTE:     mem_rdata <= {24'h0, dmem[mem_addr[7:0]]};
                    HALFWORD: mem_rdata <= {16'h0, dmem[8'(mem_addr)], dmem[8'(mem_addr + 1)]};
                    default:  mem_rdata <= {dmem[8'(mem_addr)], dmem[8'(mem_addr + 1)],
                                            dmem[8'(mem_addr + 2)], dmem[8'(mem_addr + 3)]};
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (mem_read && mem_write) both_seen = 1'b1;
        if (mem_read || mem_write) n_access++;
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == BYTE) ? 1 : (sz == HALFWORD) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic un);
        longint v;
        int n;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[8'(a + 32'(i))]);
        if (!un && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        return 32'(v);
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int n;
        n = nbytes(sz);
        for (int i = 0; i < n; i++) ref_mem[8'(a + 32'(i))] = 8'(d >> (8 * (n - 1 - i)));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request: present at a negedge while ready, scramble inputs after accept, time the response.
    task automatic txn(input logic st, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                       input logic un, output logic [31:0] rd, output logic flt, output int lat);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!req_ready && guard < 50) begin @(negedge clock); guard++; end
        req_valid = 1'b1; req_is_store = st; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = un;
        @(posedge clock); #1;
        req_valid = 1'b0; req_is_store = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom_range(0, 2)); req_unsigned = 1'($urandom);
        lat = 0;
        do begin @(negedge clock); lat++; end while (!resp_valid && lat < 40);
        rd = resp_rdata;
        flt = resp_fault;
        @(negedge clock);
        check("resp_single_cycle", 32'(resp_valid), 32'd0);
    endtask

    task automatic run_req(input string tag, input logic st, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic un, output logic [31:0] rd);
        logic flt, mis, exp_flt;
        int lat, exp_lat, n;
        logic [31:0] exp_rd;
        n = nbytes(sz);
        mis = (sz == HALFWORD && a[0]) || (sz == WORD && a[1:0] != 2'b00);
        exp_flt = mis && !SPLIT;
        exp_lat = !mis ? 2 : (SPLIT ? 2*n + 1 : 1);
        if (st && !exp_flt) model_store(a, wd, sz);
        exp_rd = (st || exp_flt) ? 32'h0 : model_load(a, sz, un);
        txn(st, a, wd, sz, un, rd, flt, lat);
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".fault"}, 32'(flt), 32'(exp_flt));
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] rd, wd, a;
        logic [1:0] sz;
        logic st, un;
        int acc0, t, accepted, responded, prev_acc, gap_bad, resp_seen;
        logic [31:0] q_exp [$];

        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        reset_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0;
        req_wdata = '0; req_size = WORD; req_unsigned = 1'b0;
        repeat (3) @(negedge clock);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_fault", 32'(resp_fault), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check("rst.how_much", 32'(mem_how_much), 32'(WORD));
        reset_n = 1'b1;

        run_req("sw10", 1'b1, 32'h10, 32'hDEADBEEF, WORD, 1'b0, rd);
        run_req("lw10", 1'b0, 32'h10, 32'h0, WORD, 1'b0, rd);
        check("lw10.lit", rd, 32'hDEADBEEF);

        run_req("sb21", 1'b1, 32'h21, 32'h0000_0080, BYTE, 1'b0, rd);
        run_req("lb21", 1'b0, 32'h21, 32'h0, BYTE, 1'b0, rd);
        check("lb21.lit", rd, 32'hFFFFFF80);
        run_req("lbu21", 1'b0, 32'h21, 32'h0, BYTE, 1'b1, rd);
        check("lbu21.lit", rd, 32'h00000080);
        run_req("lbu20", 1'b0, 32'h20, 32'h0, BYTE, 1'b1, rd);
        check("lbu20.kept", rd, 32'(init_byte(32'h20)));
        run_req("lbu22", 1'b0, 32'h22, 32'h0, BYTE, 1'b1, rd);
        run_req("lbu23", 1'b0, 32'h23, 32'h0, BYTE, 1'b1, rd);
        check("lbu23.kept", rd, 32'(init_byte(32'h23)));

        run_req("sh32", 1'b1, 32'h32, 32'hABCD_8001, HALFWORD, 1'b0, rd);
        run_req("lh32", 1'b0, 32'h32, 32'h0, HALFWORD, 1'b0, rd);
        check("lh32.lit", rd, 32'hFFFF8001);
        run_req("lhu32", 1'b0, 32'h32, 32'h0, HALFWORD, 1'b1, rd);
        check("lhu32.lit", rd, 32'h00008001);
        run_req("lw30", 1'b0, 32'h30, 32'h0, WORD, 1'b0, rd);
        check("lw30.lowhalf", 32'(rd[15:0]), 32'h8001);

`ifdef MISALIGNED_SPLIT_EN
        run_req("sw41", 1'b1, 32'h41, 32'h11223344, WORD, 1'b0, rd);
        run_req("lw41", 1'b0, 32'h41, 32'h0, WORD, 1'b0, rd);
        check("lw41.lit", rd, 32'h11223344);
        run_req("lbu41", 1'b0, 32'h41, 32'h0, BYTE, 1'b1, rd);
        check("lbu41.lit", rd, 32'h11);
        run_req("lbu44", 1'b0, 32'h44, 32'h0, BYTE, 1'b1, rd);
        check("lbu44.lit", rd, 32'h44);
`else
        acc0 = n_access;
        run_req("lw41", 1'b0, 32'h41, 32'h0, WORD, 1'b0, rd);
        check("lw41.no_access", 32'(n_access - acc0), 32'd0);
`endif

        // Reset during the ISSUE cycle of a store; its data equals the model contents.
        wd = model_load(32'h60, WORD, 1'b0);
        @(negedge clock);
        req_valid = 1'b1; req_is_store = 1'b1; req_addr = 32'h60; req_wdata = wd;
        req_size = WORD; req_unsigned = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock);
        check("rstmid.issue_write", 32'(mem_write), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstmid.write_drop", 32'(mem_write), 32'd0);
        check("rstmid.ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        resp_seen = 0;
        repeat (4) begin @(negedge clock); if (resp_valid) resp_seen++; end
        check("rstmid.no_resp", 32'(resp_seen), 32'd0);
        check("rstmid.ready_after", 32'(req_ready), 32'd1);
        run_req("rstmid.lw60", 1'b0, 32'h60, 32'h0, WORD, 1'b0, rd);

        // Back-to-back loads with req_valid held high.
        accepted = 0; responded = 0; prev_acc = -1; gap_bad = 0; t = 0;
        req_is_store = 1'b0; req_size = WORD; req_unsigned = 1'b0;
        @(negedge clock);
        while ((accepted < 5 || responded < 5) && t < 60) begin
            if (resp_valid) begin
                if (q_exp.size() > 0) check("b2b.rdata", resp_rdata, q_exp.pop_front());
                else check("b2b.extra_resp", 32'd1, 32'd0 + 32'(q_exp.size()));
                responded++;
            end
            if (req_ready && accepted < 5) begin
                if (prev_acc >= 0 && t - prev_acc != 3) gap_bad++;
                prev_acc = t;
                req_valid = 1'b1;
                req_addr = 32'h80 + 32'(4 * accepted);
                q_exp.push_back(model_load(req_addr, WORD, 1'b0));
                accepted++;
            end else if (accepted >= 5) begin
                req_valid = 1'b0;
            end
            @(negedge clock);
            t++;
        end
        req_valid = 1'b0;
        check("b2b.accepted", 32'(accepted), 32'd5);
        check("b2b.responded", 32'(responded), 32'd5);
        check("b2b.gap3", 32'(gap_bad), 32'd0);

        // Randomized mix, checked against the byte-array model.
        for (int k = 0; k < 30; k++) begin
            sz = 2'($urandom_range(0, 2));
            st = 1'($urandom_range(0, 1));
            un = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 255));
            wd = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
            run_req("rnd", st, a, wd, sz, un, rd);
        end

        check("mem_rw_exclusive", 32'(both_seen), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
